gpr_writeback: RTL and testbench
================================

// Module: gpr_writeback
// PURPOSE
//  Write-side master for the 8x16 general-purpose register file.
//  Merges results from the ALU (buffered, valid/ready) and the load/store unit (priority path) into the
//  single register-file write port (we/ws/wd), one write per cycle.
//  Keeps a per-register pending scoreboard so issue logic can stall on unresolved destinations.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  DATA_W     16  width of result data and of wd
//  ADDR_W     3   register index width; NREG = 2**ADDR_W = 8
//  FIFO_DEPTH 2   ALU result buffer entries (power of two, >=2)
//  STARVE_MAX 4   consecutive LSU wins while the ALU FIFO is non-empty before the ALU is forced through
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous reset, active-low
//  alu_valid  in   1       ALU result offered
//  alu_ready  out  1       ALU result accepted when alu_valid & alu_ready
//  alu_rd     in   ADDR_W  ALU destination register
//  alu_data   in   DATA_W  ALU result
//  lsu_valid  in   1       load result offered
//  lsu_ready  out  1       load result accepted when lsu_valid & lsu_ready
//  lsu_rd     in   ADDR_W  load destination register
//  lsu_data   in   DATA_W  load data
//  iss_valid  in   1       issue stage reserves a destination this cycle
//  iss_rd     in   ADDR_W  reserved destination
//  busy       out  NREG    bit i = 1: register i has a result outstanding
//  we         out  1       register-file write enable (registered)
//  ws         out  ADDR_W  register-file write select (registered)
//  wd         out  DATA_W  register-file write data (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): we=0, ws=0, wd=0, busy=0, FIFO emptied (entries discarded), starve count=0.
//   A reset mid-operation drops all buffered and in-flight results; no write issues in the cycle after reset.
//  Ready: alu_ready = (fifo_count < FIFO_DEPTH); depends on count only, never on same-cycle pop.
//   lsu_ready = 1 except in a forced cycle (starve count == STARVE_MAX and FIFO non-empty).
//  Select (combinational, priority order):
//   1) forced cycle -> FIFO head;
//   2) lsu_valid & lsu_ready -> LSU input;
//   3) FIFO non-empty -> FIFO head (pop);
//   4) alu_valid & FIFO empty -> ALU input, bypasses FIFO (not enqueued);
//   5) nothing -> we=0 next cycle.
//  An accepted ALU result that is not bypassed is pushed at the edge; push and pop in the same cycle are allowed.
//  Latency: exactly 1 cycle from selection to we=1 with ws/wd; ALU results leave the FIFO in order.
//  Starve counter: +1 on each LSU win while FIFO non-empty; cleared on any FIFO pop or when FIFO empty; saturates.
//  Scoreboard, at each edge:
//   - busy[iss_rd] is set if iss_valid;
//   - busy[ws] is cleared if we=1 (the same edge the register file captures wd).
//   - Set and clear on the same index in one cycle: set wins (re-reservation).
//   - Writes to non-busy registers are legal and leave busy unchanged.
//  All registers, including r0, are writable; there is no hardwired zero.
//  ws/wd hold their last value while we=0.
// TESTING
//  1. Reset with FIFO holding 2 entries -> next cycle we=0, busy=0, alu_ready=1; the entries are never written.
//  2. ALU only: alu_valid with rd=3, data=0x1234, FIFO empty -> next cycle we=1, ws=3, wd=0x1234 (bypass).
//  3. Same cycle: lsu rd=1 data=0xAAAA and alu rd=2 data=0x5555 -> cycle+1 writes r1 (0xAAAA), cycle+2 writes r2 (0x5555).
//  4. lsu_valid held high, 3 ALU results pushed -> after 4 LSU writes lsu_ready=0 for 1 cycle and one ALU result writes;
//     FIFO full holds alu_ready=0.
//  5. iss_valid rd=5 -> busy[5]=1; a later result to r5 -> busy[5]=0 at the edge with we=1;
//     iss rd=5 in that same cycle -> busy[5] stays 1.
//  6. Random mix over 10k cycles vs. reference model: every accepted result written exactly once,
//     ALU order preserved, busy matches the model.

Source files
------------

// File: rtl/gpr_writeback.sv
// rtl/gpr_writeback.sv - register-file write-port arbiter with ALU result buffer and pending scoreboard
module gpr_writeback #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [ADDR_W-1:0]      lsu_rd,
  input  logic [DATA_W-1:0]      lsu_data,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   we,
  output logic [ADDR_W-1:0]      ws,
  output logic [DATA_W-1:0]      wd
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve;

  logic              fifo_empty;
  logic              forced;
  logic              alu_acc;
  logic              lsu_acc;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              pop;
  logic              push;
  logic              bypass;
  logic              lsu_win;
  logic [NREG-1:0]   busy_nxt;

  // Forced cycle: the LSU has starved a non-empty ALU buffer long enough
  assign fifo_empty = (count == '0);
  assign forced     = (starve == SC_W'(STARVE_MAX)) && !fifo_empty;
  assign alu_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign lsu_ready  = !forced;
  assign alu_acc    = alu_valid & alu_ready;
  assign lsu_acc    = lsu_valid & lsu_ready;
  assign push       = alu_acc & ~bypass;

  // Write-port source selection in priority order
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = fifo_rd[rd_ptr];
    sel_data  = fifo_data[rd_ptr];
    pop       = 1'b0;
    bypass    = 1'b0;
    lsu_win   = 1'b0;
    if (forced) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
    end else if (lsu_acc) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
      lsu_win   = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      pop       = 1'b1;
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      bypass    = 1'b1;
    end
  end

  // ALU buffer storage; contents are don't-care while not counted
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= alu_data;
      fifo_rd[wr_ptr]   <= alu_rd;
    end
  end

  // ALU buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Count LSU wins that leave buffered ALU results waiting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (pop || fifo_empty) begin
      starve <= '0;
    end else if (lsu_win && (starve != SC_W'(STARVE_MAX))) begin
      starve <= starve + 1'b1;
    end
  end

  // Registered write port; ws/wd keep their last value when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we <= 1'b0;
      ws <= '0;
      wd <= '0;
    end else begin
      we <= sel_valid;
      if (sel_valid) begin
        ws <= sel_rd;
        wd <= sel_data;
      end
    end
  end

  // Pending scoreboard update; a same-index reservation overrides the clear
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[ws] = 1'b0;
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_gpr_writeback.sv
// tb/tb_gpr_writeback.sv - scoreboard bench for gpr_writeback
module tb_gpr_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [2:0]  lsu_rd;
  logic [15:0] lsu_data;
  logic        iss_valid;
  logic [2:0]  iss_rd;
  logic [7:0]  busy;
  logic        we;
  logic [2:0]  ws;
  logic [15:0] wd;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;

  gpr_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
    .we(we), .ws(ws), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [2:0] rd, input logic [15:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic drive(input logic av, input logic [2:0] ard, input logic [15:0] ad,
                       input logic lv, input logic [2:0] lrd, input logic [15:0] ld,
                       input logic iv, input logic [2:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_valid = iv; iss_rd = ird;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every register-file write must match the next expected write
  always @(posedge clk) begin
    #1;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got ws=%0d wd=%0h expected no write", ws, wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_ws_wd", {13'd0, ws, wd}, {13'd0, mon_e});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rd = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_ws", {29'd0, ws}, 0);
    chk("rst_wd", {16'd0, wd}, 0);
    chk("rst_busy", {24'd0, busy}, 0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 1);
    chk("rst_lsu_ready", {31'd0, lsu_ready}, 1);
    rst_n = 1'b1;
    idle(1);

    // ALU bypass with empty buffer
    expect_wr(3, 16'h1234);
    drive(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    chk("bypass_we", {31'd0, we}, 1);
    idle(1);
    chk("hold_we", {31'd0, we}, 0);
    chk("hold_ws", {29'd0, ws}, 3);
    chk("hold_wd", {16'd0, wd}, 16'h1234);

    // Simultaneous LSU and ALU: LSU first, ALU next cycle
    expect_wr(1, 16'hAAAA);
    expect_wr(2, 16'h5555);
    drive(1, 2, 16'h5555, 1, 1, 16'hAAAA, 0, 0);
    idle(3);

    // LSU starvation of buffered ALU results
    for (int i = 0; i < 5; i++) expect_wr(7, 16'h7000 + 16'(i));
    expect_wr(4, 16'h0A01);
    expect_wr(7, 16'h7005);
    expect_wr(5, 16'h0B02);
    expect_wr(6, 16'h0C03);
    drive(1, 4, 16'h0A01, 1, 7, 16'h7000, 0, 0);
    drive(1, 5, 16'h0B02, 1, 7, 16'h7001, 0, 0);
    chk("full_alu_ready", {31'd0, alu_ready}, 0);
    drive(1, 6, 16'h0C03, 1, 7, 16'h7002, 0, 0);
    drive(1, 6, 16'h0C03, 1, 7, 16'h7003, 0, 0);
    chk("notyet_lsu_ready", {31'd0, lsu_ready}, 1);
    drive(1, 6, 16'h0C03, 1, 7, 16'h7004, 0, 0);
    chk("forced_lsu_ready", {31'd0, lsu_ready}, 0);
    chk("forced_alu_ready", {31'd0, alu_ready}, 0);
    drive(1, 6, 16'h0C03, 1, 7, 16'h7005, 0, 0);
    chk("after_force_lsu_ready", {31'd0, lsu_ready}, 1);
    chk("after_force_alu_ready", {31'd0, alu_ready}, 1);
    drive(1, 6, 16'h0C03, 1, 7, 16'h7005, 0, 0);
    idle(4);

    // Scoreboard set / clear / re-reservation
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    chk("busy_set", {24'd0, busy}, 32'h20);
    expect_wr(5, 16'h5A5A);
    drive(1, 5, 16'h5A5A, 0, 0, 0, 0, 0);
    chk("busy_before_clear", {24'd0, busy}, 32'h20);
    idle(1);
    chk("busy_cleared", {24'd0, busy}, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    expect_wr(5, 16'h6B6B);
    drive(1, 5, 16'h6B6B, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    chk("busy_set_wins", {24'd0, busy}, 32'h20);
    expect_wr(0, 16'h0F0F);
    drive(0, 0, 0, 1, 0, 16'h0F0F, 1, 2);
    idle(1);
    chk("busy_nonbusy_write", {24'd0, busy}, 32'h24);
    expect_wr(2, 16'h2A2A);
    drive(0, 0, 0, 1, 2, 16'h2A2A, 0, 0);
    idle(1);
    chk("busy_clear_r2", {24'd0, busy}, 32'h20);

    // Reset with two buffered ALU results: they must never be written
    expect_wr(0, 16'h1111);
    expect_wr(0, 16'h3333);
    drive(1, 1, 16'h2222, 1, 0, 16'h1111, 1, 6);
    drive(1, 2, 16'h4444, 1, 0, 16'h3333, 0, 0);
    chk("prerst_alu_ready", {31'd0, alu_ready}, 0);
    chk("prerst_busy", {24'd0, busy}, 32'h60);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    chk("midrst_we", {31'd0, we}, 0);
    chk("midrst_busy", {24'd0, busy}, 0);
    chk("midrst_alu_ready", {31'd0, alu_ready}, 1);
    idle(4);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
